// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and constants for the multiply/divide sequencer
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam logic [63:0] DIV0_LO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_div_op(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     rem_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out,
  output logic [WIDTH-1:0]     rem_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Divide keeps the dividend/quotient in acc_in[WIDTH-1:0]; multiply uses the full accumulator.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
    shifted = {rem_in, acc_in[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    acc_out = {sum, acc_in[WIDTH-1:1]};
    rem_out = rem_in;
    if (is_div) begin
      rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MIPS multiply/divide sequencer owning the HI/LO registers
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           op_q;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     rem_nx;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     rs_raw;
  logic                 neg_q;
  logic                 neg_rem_q;
  logic                 div0_q;

  logic                 sgn;
  logic [WIDTH-1:0]     rs_abs;
  logic [WIDTH-1:0]     rt_abs;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign sgn      = is_signed_op(op);
  assign rs_abs   = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs   = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem : rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_op(op_q)),
    .acc_in  (acc),
    .rem_in  (rem),
    .opnd    (opnd),
    .acc_out (acc_nx),
    .rem_out (rem_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_MULTU;
      acc         <= '0;
      rem         <= '0;
      opnd        <= '0;
      rs_raw      <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // A squash drops any in-flight result and any same-cycle request.
        if (state != IDLE) div_by_zero <= 1'b0;
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
            if (start) begin
              op_q        <= op;
              rs_raw      <= rs_val;
              neg_q       <= sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_rem_q   <= sgn & rs_val[WIDTH-1];
              div0_q      <= is_div_op(op) && (rt_val == '0);
              rem         <= '0;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
              if (is_div_op(op)) begin
                acc  <= {{WIDTH{1'b0}}, rs_abs};
                opnd <= rt_abs;
              end else begin
                acc  <= {{WIDTH{1'b0}}, rt_abs};
                opnd <= rs_abs;
              end
            end
          end
          RUN: begin
            acc <= acc_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
          end
          FIX: begin
            if (!is_div_op(op_q)) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div0_q) begin
              hi <= rs_raw;
              lo <= DIV0_LO[WIDTH-1:0];
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
            div_by_zero <= div0_q;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq: vector table, corner sequences, random vs arithmetic model
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic, returns {dz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (o == OP_MULTU || o == OP_MULT) begin
      if (o == OP_MULT) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      p = 64'(sa * sb);
      return {1'b0, p};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (o == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  // Starts at a negedge, returns at the negedge where done is seen (or after a budget).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at, output int lat);
    bit busy_ok;
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      start = (lat == glitch_at);
      if (start) begin
        op = OP_MULTU; rs_val = 32'h0000_0BAD; rt_val = 32'h0000_0BAD;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("busy_held", 64'(busy_ok), 64'd1);
    check("latency", 64'(lat), 64'd33);
    check("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  int          lat;
  logic [64:0] exp_m;
  logic [31:0] ra, rb;
  logic [1:0]  ro;

  initial begin
    vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{OP_DIVU,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, lat);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d_dz", i), 64'(div_by_zero), 64'(vecs[i].dz));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // MTHI/MTLO preload, then a flushed MULTU with ignored writes while busy.
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", 64'(hi), 64'h1234);
    check("mtlo", 64'(lo), 64'h5678);
    op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      hi_we = (c == 5); lo_we = (c == 5); wdata = 32'h0BAD;
      flush = (c == 10);
      @(negedge clk);
    end
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (done || busy) saw_done = 1'b1;
        @(negedge clk);
      end
      check("flush_no_done", 64'(saw_done), 64'd0);
    end
    check("flush_hi", 64'(hi), 64'h1234);
    check("flush_lo", 64'(lo), 64'h5678);
    check("flush_dz", 64'(div_by_zero), 64'd0);

    // Back-to-back: second op starts on the done cycle; a stray start mid-run is ignored.
    run_op(OP_MULTU, 32'd3, 32'd4, -1, lat);
    check("b2b_first_lo", 64'(lo), 64'd12);
    run_op(OP_DIVU, 32'd1000, 32'd7, 5, lat);
    check("b2b_second_lo", 64'(lo), 64'd142);
    check("b2b_second_hi", 64'(hi), 64'd6);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      exp_m = model(ro, ra, rb);
      run_op(ro, ra, rb, -1, lat);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), {hi, lo}, exp_m[63:0]);
      check($sformatf("rnd%0d_dz", i), 64'(div_by_zero), 64'(exp_m[64]));
    end

    // Asynchronous reset in the middle of RUN.
    op = OP_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_MULT, 32'hFFFF_FFFB, 32'd5, -1, lat);
    check("post_rst_hi", 64'(hi), 64'hFFFF_FFFF);
    check("post_rst_lo", 64'(lo), 64'hFFFF_FFE7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
